// File: rtl/dispatcher_cpu_scheduler_pkg.sv
// Shared types and constants for the dispatcher CPU-thread scheduler.
package dispatcher_sched_pkg;

  localparam int unsigned NUM_THREADS = 32;
  localparam int unsigned ID_W        = 5;
  localparam int unsigned MAX_CREDIT  = 8;
  localparam int unsigned CREDIT_W    = 4;

  typedef enum logic [1:0] {IDLE, PICK, RESP} sched_state_e;

  localparam logic RR   = 1'b0;
  localparam logic BIND = 1'b1;

endpackage

// File: rtl/dispatcher_cpu_scheduler_if.sv
// Request/response, configuration and credit-return bundle for the scheduler.
interface dispatcher_cpu_scheduler_if;
  import dispatcher_sched_pkg::*;

  logic                   in_fpgaac_cpuid_cs;
  logic [5:0]             in_fpgaac_channel_num;
  logic [NUM_THREADS-1:0] cpuid_valid;
  logic                   in_input_ctl;
  logic [ID_W-1:0]        in_input_key;
  logic                   in_credit_ret_wr;
  logic [ID_W-1:0]        in_credit_ret_id;
  logic [ID_W-1:0]        out_input_cpuid;
  logic                   out_input_ack;
  logic                   out_input_valid;
  logic [NUM_THREADS-1:0] out_credit_empty;

  modport master (
    output in_fpgaac_cpuid_cs, in_fpgaac_channel_num, cpuid_valid, in_input_ctl, in_input_key,
    output in_credit_ret_wr, in_credit_ret_id,
    input  out_input_cpuid, out_input_ack, out_input_valid, out_credit_empty
  );

  modport slave (
    input  in_fpgaac_cpuid_cs, in_fpgaac_channel_num, cpuid_valid, in_input_ctl, in_input_key,
    input  in_credit_ret_wr, in_credit_ret_id,
    output out_input_cpuid, out_input_ack, out_input_valid, out_credit_empty
  );

endinterface

// File: rtl/dispatcher_rr_pick.sv
// Combinational rotating-priority first-one finder: lowest set bit at or above i_start, wrapping.
module dispatcher_rr_pick
  import dispatcher_sched_pkg::*;
(
  input  logic [NUM_THREADS-1:0] i_mask,
  input  logic [ID_W-1:0]        i_start,
  output logic [ID_W-1:0]        o_id,
  output logic                   o_found
);

  logic [2*NUM_THREADS-1:0] w_dbl;
  logic [NUM_THREADS-1:0]   w_rot;
  logic [ID_W-1:0]          w_off;

  // Rotate so bit 0 of w_rot corresponds to thread i_start.
  assign w_dbl = {i_mask, i_mask} >> i_start;
  assign w_rot = w_dbl[NUM_THREADS-1:0];

  always_comb begin
    w_off   = '0;
    o_found = 1'b0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = ID_W'(i);
        o_found = 1'b1;
      end
    end
  end

  assign o_id = i_start + w_off;

endmodule

// File: rtl/dispatcher_cpu_scheduler.sv
// Credit-aware CPU-thread scheduler (round-robin or port-bind).
// Credit tracking is enabled by defining DISPATHER_SCHED_CREDIT_EN.
module dispatcher_cpu_scheduler #(
  parameter int unsigned NUM_THREADS = dispatcher_sched_pkg::NUM_THREADS,
  parameter int unsigned MAX_CREDIT  = dispatcher_sched_pkg::MAX_CREDIT,
  parameter int unsigned CREDIT_W    = dispatcher_sched_pkg::CREDIT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  dispatcher_cpu_scheduler_if.slave  bus
);
  import dispatcher_sched_pkg::*;

  sched_state_e           r_state;
  logic                   r_mode;
  logic [ID_W-1:0]        r_key;
  logic [ID_W-1:0]        r_last;
  logic [ID_W-1:0]        r_cpuid;
  logic                   r_ack;
  logic                   r_valid;

  logic [5:0]             w_chan;
  logic [NUM_THREADS-1:0] w_avail;
  logic [NUM_THREADS-1:0] w_elig;
  logic [ID_W-1:0]        w_start;
  logic [ID_W-1:0]        w_rr_id;
  logic                   w_rr_found;

  assign w_chan = (bus.in_fpgaac_channel_num > 6'(NUM_THREADS)) ? 6'(NUM_THREADS)
                                                                  : bus.in_fpgaac_channel_num;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_elig[i] = bus.cpuid_valid[i] & (6'(i) < w_chan) & w_avail[i];
    end
  end

  assign w_start = r_last + ID_W'(1);

  dispatcher_rr_pick u_rr_pick (
    .i_mask  (w_elig),
    .i_start (w_start),
    .o_id    (w_rr_id),
    .o_found (w_rr_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mode  <= RR;
      r_key   <= '0;
      r_last  <= ID_W'(NUM_THREADS - 1);
      r_cpuid <= '0;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_input_ctl) begin
            r_key   <= bus.in_input_key;
            r_mode  <= bus.in_fpgaac_cpuid_cs;
            r_state <= PICK;
          end
        end
        PICK: begin
          r_ack   <= 1'b1;
          r_state <= RESP;
          if (r_mode == BIND) begin
            r_cpuid <= r_key;
            r_valid <= w_elig[r_key];
          end else begin
            r_cpuid <= w_rr_id;
            r_valid <= w_rr_found;
            if (w_rr_found) r_last <= w_rr_id;
          end
        end
        RESP: begin
          r_ack   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_input_ack   = r_ack;
  assign bus.out_input_valid = r_valid;
  assign bus.out_input_cpuid = r_cpuid;

`ifdef DISPATHER_SCHED_CREDIT_EN
  logic [CREDIT_W-1:0]    r_credit [NUM_THREADS];
  logic                   w_grant;
  logic [NUM_THREADS-1:0] w_dec;
  logic [NUM_THREADS-1:0] w_inc;

  // r_valid/r_cpuid are fresh during RESP, so the grant is charged then.
  assign w_grant = (r_state == RESP) & r_valid;

  always_comb begin
    w_dec   = '0;
    w_inc   = '0;
    w_avail = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_dec[i]   = w_grant && (r_cpuid == ID_W'(i));
      w_inc[i]   = bus.in_credit_ret_wr && (bus.in_credit_ret_id == ID_W'(i));
      w_avail[i] = (r_credit[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) r_credit[i] <= CREDIT_W'(MAX_CREDIT);
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (w_dec[i] && !w_inc[i]) begin
          r_credit[i] <= r_credit[i] - CREDIT_W'(1);
        end else if (w_inc[i] && !w_dec[i] && (r_credit[i] != CREDIT_W'(MAX_CREDIT))) begin
          r_credit[i] <= r_credit[i] + CREDIT_W'(1);
        end
      end
    end
  end

  assign bus.out_credit_empty = ~w_avail;
`else
  logic                w_unused_ret;
  logic [CREDIT_W-1:0] w_unused_credit;

  assign w_unused_ret     = ^{bus.in_credit_ret_wr, bus.in_credit_ret_id};
  assign w_unused_credit  = CREDIT_W'(MAX_CREDIT);
  assign w_avail          = '1;
  assign bus.out_credit_empty = '0;
`endif

endmodule

// File: tb/tb_dispatcher_cpu_scheduler.sv
// Directed self-checking bench for dispatcher_cpu_scheduler; expectations adapt to
// whether DISPATHER_SCHED_CREDIT_EN is defined.
module tb_dispatcher_cpu_scheduler;
  import dispatcher_sched_pkg::*;

`ifdef DISPATHER_SCHED_CREDIT_EN
  localparam bit CrOn = 1'b1;
`else
  localparam bit CrOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dispatcher_cpu_scheduler_if bus ();

  dispatcher_cpu_scheduler #(
    .NUM_THREADS (32),
    .MAX_CREDIT  (8),
    .CREDIT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_input_ctl     = 1'b0;
    bus.in_credit_ret_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_cfg(input logic mode, input logic [5:0] ch, input logic [31:0] mask);
    @(negedge clk);
    bus.in_fpgaac_cpuid_cs    = mode;
    bus.in_fpgaac_channel_num = ch;
    bus.cpuid_valid           = mask;
  endtask

  // One request; optionally pulses a credit return during the ack (RESP) cycle.
  task automatic request(input logic [4:0] key, input bit ret_in_resp, input logic [4:0] rid,
                         output logic [4:0] id, output logic vld, output int lat,
                         output logic ack_after);
    @(negedge clk);
    bus.in_input_ctl = 1'b1;
    bus.in_input_key = key;
    @(negedge clk);
    bus.in_input_ctl = 1'b0;
    lat = 1;
    while (bus.out_input_ack !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    id  = bus.out_input_cpuid;
    vld = bus.out_input_valid;
    if (ret_in_resp) begin
      bus.in_credit_ret_wr = 1'b1;
      bus.in_credit_ret_id = rid;
    end
    @(negedge clk);
    bus.in_credit_ret_wr = 1'b0;
    ack_after = bus.out_input_ack;
  endtask

  task automatic req_chk(input string tag, input logic [4:0] key, input bit ret_in_resp,
                         input logic [4:0] rid, input logic [4:0] exp_id, input logic exp_vld,
                         input bit chk_id);
    logic [4:0] id;
    logic       vld;
    int         lat;
    logic       ack_after;
    request(key, ret_in_resp, rid, id, vld, lat, ack_after);
    check({tag, ".lat"}, 32'(lat), 32'd2);
    check({tag, ".valid"}, {31'd0, vld}, {31'd0, exp_vld});
    check({tag, ".ack_drop"}, {31'd0, ack_after}, 32'd0);
    if (chk_id) check({tag, ".id"}, {27'd0, id}, {27'd0, exp_id});
  endtask

  task automatic give_credit(input logic [4:0] id, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_credit_ret_wr = 1'b1;
      bus.in_credit_ret_id = id;
    end
    @(negedge clk);
    bus.in_credit_ret_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rr_basic [6];
    logic [4:0] rr_holes [4];
    logic       ack_seen;
    rr_basic = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1};
    rr_holes = '{5'd1, 5'd4, 5'd1, 5'd4};

    reset                     = 1'b1;
    bus.in_fpgaac_cpuid_cs    = RR;
    bus.in_fpgaac_channel_num = 6'd32;
    bus.cpuid_valid           = 32'hFFFF_FFFF;
    bus.in_input_ctl          = 1'b0;
    bus.in_input_key          = 5'd0;
    bus.in_credit_ret_wr      = 1'b0;
    bus.in_credit_ret_id      = 5'd0;
    do_reset();

    check("reset.ack",   {31'd0, bus.out_input_ack},   32'd0);
    check("reset.valid", {31'd0, bus.out_input_valid}, 32'd0);
    check("reset.cpuid", {27'd0, bus.out_input_cpuid}, 32'd0);
    check("reset.empty", bus.out_credit_empty,         32'd0);

    set_cfg(RR, 6'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) req_chk($sformatf("rr_basic%0d", i), 5'd0, 0, 5'd0,
                                        rr_basic[i], 1'b1, 1);

    do_reset();
    set_cfg(RR, 6'd32, 32'h0000_0012);
    for (int i = 0; i < 4; i++) req_chk($sformatf("rr_holes%0d", i), 5'd0, 0, 5'd0,
                                        rr_holes[i], 1'b1, 1);

    set_cfg(BIND, 6'd8, 32'hFFFF_FFFF);
    req_chk("bind7", 5'd7, 0, 5'd0, 5'd7, 1'b1, 1);
    req_chk("bind9_out", 5'd9, 0, 5'd0, 5'd9, 1'b0, 0);

    // Key 9 must still hold a full credit load after the refused request.
    set_cfg(BIND, 6'd32, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) req_chk($sformatf("bind9_g%0d", i), 5'd9, 0, 5'd0,
                                        5'd9, 1'b1, 1);
    req_chk("bind9_g8", 5'd9, 0, 5'd0, 5'd9, !CrOn, 0);

    for (int i = 0; i < 8; i++) req_chk($sformatf("exh3_g%0d", i), 5'd3, 0, 5'd0,
                                        5'd3, 1'b1, 1);
    req_chk("exh3_g8", 5'd3, 0, 5'd0, 5'd3, !CrOn, 0);
    check("exh3.empty", bus.out_credit_empty, CrOn ? 32'h0000_0208 : 32'd0);
    give_credit(5'd3, 1);
    check("exh3.empty_ret", bus.out_credit_empty, CrOn ? 32'h0000_0200 : 32'd0);
    req_chk("exh3_after_ret", 5'd3, 0, 5'd0, 5'd3, 1'b1, 1);

    do_reset();
    set_cfg(BIND, 6'd32, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) req_chk($sformatf("sim2_pre%0d", i), 5'd2, 0, 5'd0,
                                        5'd2, 1'b1, 1);
    req_chk("sim2_same", 5'd2, 1, 5'd2, 5'd2, 1'b1, 1);
    for (int i = 0; i < 5; i++) req_chk($sformatf("sim2_post%0d", i), 5'd2, 0, 5'd0,
                                        5'd2, 1'b1, 1);
    req_chk("sim2_last", 5'd2, 0, 5'd0, 5'd2, !CrOn, 0);

    give_credit(5'd5, 10);
    for (int i = 0; i < 8; i++) req_chk($sformatf("sat5_g%0d", i), 5'd5, 0, 5'd0,
                                        5'd5, 1'b1, 1);
    req_chk("sat5_g8", 5'd5, 0, 5'd0, 5'd5, !CrOn, 0);
    check("sat5.empty", bus.out_credit_empty, CrOn ? 32'h0000_0024 : 32'd0);

    req_chk("diff6_ret2", 5'd6, 1, 5'd2, 5'd6, 1'b1, 1);
    check("diff.empty", bus.out_credit_empty, CrOn ? 32'h0000_0020 : 32'd0);
    req_chk("diff2_a", 5'd2, 0, 5'd0, 5'd2, 1'b1, 1);
    req_chk("diff2_b", 5'd2, 0, 5'd0, 5'd2, !CrOn, 0);

    do_reset();
    set_cfg(BIND, 6'd32, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) req_chk($sformatf("rst0_g%0d", i), 5'd0, 0, 5'd0,
                                        5'd0, 1'b1, 1);
    check("rst0.empty", bus.out_credit_empty, CrOn ? 32'h0000_0001 : 32'd0);
    set_cfg(RR, 6'd32, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.in_input_ctl = 1'b1;
    bus.in_input_key = 5'd0;
    @(negedge clk);
    bus.in_input_ctl = 1'b0;
    reset = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ack_seen = ack_seen | bus.out_input_ack;
    end
    reset = 1'b0;
    @(negedge clk);
    ack_seen = ack_seen | bus.out_input_ack;
    check("rst_pick.no_ack", {31'd0, ack_seen}, 32'd0);
    check("rst_pick.empty", bus.out_credit_empty, 32'd0);
    req_chk("rst_pick.rr", 5'd0, 0, 5'd0, 5'd0, 1'b1, 1);

    set_cfg(RR, 6'd0, 32'hFFFF_FFFF);
    req_chk("ch0", 5'd0, 0, 5'd0, 5'd0, 1'b0, 0);
    set_cfg(RR, 6'd40, 32'h0000_0000);
    req_chk("mask0", 5'd0, 0, 5'd0, 5'd0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
